// File: rtl/yari_mem_arbiter.sv
// Two-port (data / instruction) memory arbiter with D priority, I starvation override,
// hold-until-accept locking, per-port outstanding-read limits and a zero-latency return path.
module yari_mem_arbiter #(
  parameter int unsigned STARVE_LIMIT    = 8,
  parameter int unsigned MAX_OUTSTANDING = 4
) (
  input  logic        clock,
  input  logic        rst,
  input  logic        dmem_read,
  input  logic        dmem_write,
  input  logic [29:0] dmem_address,
  input  logic [31:0] dmem_writedata,
  input  logic [3:0]  dmem_writedatamask,
  output logic        dmem_waitrequest,
  output logic [31:0] dmem_readdata,
  output logic        dmem_readdatavalid,
  input  logic        imem_read,
  input  logic [29:0] imem_address,
  output logic        imem_waitrequest,
  output logic [31:0] imem_readdata,
  output logic        imem_readdatavalid,
  input  logic        mem_waitrequest,
  input  logic [31:0] mem_readdata,
  input  logic [1:0]  mem_readdataid,
  output logic [1:0]  mem_id,
  output logic [29:0] mem_address,
  output logic        mem_read,
  output logic        mem_write,
  output logic [31:0] mem_writedata,
  output logic [3:0]  mem_writedatamask,
  output logic [31:0] perf_ic_starved
);

  localparam int unsigned SW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);
  localparam logic [3:0]    OUT_MAX    = 4'(MAX_OUTSTANDING);
  localparam logic [1:0]    ID_NONE    = 2'd0;
  localparam logic [1:0]    ID_D       = 2'd1;
  localparam logic [1:0]    ID_I       = 2'd2;

  typedef enum logic [1:0] {
    ST_FREE   = 2'd0,
    ST_LOCK_D = 2'd1,
    ST_LOCK_I = 2'd2
  } lock_e;

  lock_e         state_q, state_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [3:0]    d_out_q, d_out_d, i_out_q, i_out_d;
  logic [31:0]   perf_q, perf_d;

  logic       d_req, d_elig, i_elig, force_i, forward, accept, starve_hit;
  logic [1:0] sel;
  logic       d_inc, d_dec, i_inc, i_dec;

  // Winner selection: a held lock owner beats any priority decision.
  always_comb begin
    d_req      = dmem_read | dmem_write;
    d_elig     = dmem_write | (dmem_read & (d_out_q < OUT_MAX));
    i_elig     = imem_read & (i_out_q < OUT_MAX);
    force_i    = i_elig & (starve_q == STARVE_MAX);
    sel        = ID_NONE;
    forward    = 1'b0;
    starve_hit = 1'b0;
    if (rst) begin
      sel     = ID_NONE;
      forward = 1'b0;
    end else begin
      case (state_q)
        ST_LOCK_D: begin
          sel     = ID_D;
          forward = d_req;
        end
        ST_LOCK_I: begin
          sel     = ID_I;
          forward = imem_read;
        end
        ST_FREE: begin
          if (force_i) begin
            sel        = ID_I;
            forward    = 1'b1;
            starve_hit = d_elig;
          end else if (d_elig) begin
            sel     = ID_D;
            forward = 1'b1;
          end else if (i_elig) begin
            sel     = ID_I;
            forward = 1'b1;
          end else begin
            sel     = ID_NONE;
            forward = 1'b0;
          end
        end
        default: begin
          sel     = ID_NONE;
          forward = 1'b0;
        end
      endcase
    end
    accept = forward & ~mem_waitrequest;
  end

  // Memory-side request mux, port handshakes and the return path.
  always_comb begin
    mem_id            = forward ? sel : ID_NONE;
    mem_address       = (sel == ID_I) ? imem_address : dmem_address;
    mem_writedata     = dmem_writedata;
    mem_writedatamask = dmem_writedatamask;
    mem_read          = 1'b0;
    mem_write         = 1'b0;
    if (forward && (sel == ID_D)) begin
      mem_read  = dmem_read;
      mem_write = dmem_write;
    end else if (forward && (sel == ID_I)) begin
      mem_read  = imem_read;
      mem_write = 1'b0;
    end else begin
      mem_read  = 1'b0;
      mem_write = 1'b0;
    end
    dmem_waitrequest   = (sel == ID_D) ? mem_waitrequest : 1'b1;
    imem_waitrequest   = (sel == ID_I) ? mem_waitrequest : 1'b1;
    dmem_readdatavalid = (mem_readdataid == ID_D);
    imem_readdatavalid = (mem_readdataid == ID_I);
    dmem_readdata      = mem_readdata;
    imem_readdata      = mem_readdata;
    perf_ic_starved    = perf_q;
  end

  // Next-state for lock, starvation counter, outstanding counters and perf counter.
  always_comb begin
    d_inc = accept & (sel == ID_D) & dmem_read;
    d_dec = (mem_readdataid == ID_D) & (d_out_q != 4'd0);
    i_inc = accept & (sel == ID_I);
    i_dec = (mem_readdataid == ID_I) & (i_out_q != 4'd0);

    state_d = state_q;
    if (state_q != ST_FREE) begin
      state_d = mem_waitrequest ? state_q : ST_FREE;
    end else if (mem_waitrequest && (sel == ID_D)) begin
      state_d = ST_LOCK_D;
    end else if (mem_waitrequest && (sel == ID_I)) begin
      state_d = ST_LOCK_I;
    end else begin
      state_d = ST_FREE;
    end

    starve_d = starve_q;
    if (!imem_read || (accept && (sel == ID_I))) begin
      starve_d = {SW{1'b0}};
    end else if (starve_q != STARVE_MAX) begin
      starve_d = starve_q + SW'(1'b1);
    end else begin
      starve_d = starve_q;
    end

    d_out_d = d_out_q;
    if (d_inc && !d_dec && (d_out_q != 4'hF)) begin
      d_out_d = d_out_q + 4'd1;
    end else if (d_dec && !d_inc) begin
      d_out_d = d_out_q - 4'd1;
    end else begin
      d_out_d = d_out_q;
    end

    i_out_d = i_out_q;
    if (i_inc && !i_dec && (i_out_q != 4'hF)) begin
      i_out_d = i_out_q + 4'd1;
    end else if (i_dec && !i_inc) begin
      i_out_d = i_out_q - 4'd1;
    end else begin
      i_out_d = i_out_q;
    end

    perf_d = starve_hit ? (perf_q + 32'd1) : perf_q;
  end

  // State registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (rst) begin
      state_q  <= ST_FREE;
      starve_q <= {SW{1'b0}};
      d_out_q  <= 4'd0;
      i_out_q  <= 4'd0;
      perf_q   <= 32'd0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
      d_out_q  <= d_out_d;
      i_out_q  <= i_out_d;
      perf_q   <= perf_d;
    end
  end

endmodule

// File: doc/yari_mem_arbiter.md
YARI_MEM_ARBITER -- requirements
Module: yari_mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 8: max consecutive cycles an I-port request may lose arbitration before it is forced to win.
REQ-002 The block SHALL have parameter MAX_OUTSTANDING, default 4: max accepted-but-unreturned reads per port (1..15).
REQ-003 The block SHALL have a single clock `clock`; `rst` is synchronous, active-high. Both are listed first.
REQ-004 D-port ports SHALL be:
- dmem_read in 1; dmem_write in 1; dmem_address in 30; dmem_writedata in 32; dmem_writedatamask in 4.
- dmem_waitrequest out 1; dmem_readdata out 32; dmem_readdatavalid out 1.
REQ-005 I-port ports SHALL be:
- imem_read in 1; imem_address in 30.
- imem_waitrequest out 1; imem_readdata out 32; imem_readdatavalid out 1.
REQ-006 Memory-side ports SHALL be:
- mem_waitrequest in 1; mem_readdata in 32; mem_readdataid in 2.
- mem_id out 2; mem_address out 30; mem_read out 1; mem_write out 1; mem_writedata out 32; mem_writedatamask out 4.
REQ-007 The block SHALL provide perf_ic_starved, out 32: count of cycles the starvation override was active.

Function
REQ-008 Port IDs SHALL be: D = 2'd1, I = 2'd2. ID 0 means no return data.
REQ-009 A port's request is eligible when its strobe is high and its outstanding-read count is below MAX_OUTSTANDING. D writes are always eligible.
REQ-010 When unlocked, the winner SHALL be D if eligible, else I if eligible. Exception: I wins when it is eligible and starve_cnt == STARVE_LIMIT.
REQ-011 The winner's address, read, write, writedata and mask SHALL be driven combinationally on mem_*, with mem_id = winner ID. With no winner, mem_read = mem_write = 0 and mem_id = 0.
REQ-012 Lock rule: if the winner is presented while mem_waitrequest = 1, the block SHALL set lock and lock_owner = winner.
- While locked, lock_owner alone is presented, even if the other port has higher priority.
- Lock clears on the first cycle with mem_waitrequest = 0 (the accept cycle).
REQ-013 Waitrequest outputs: the presented port's waitrequest = mem_waitrequest. The non-presented port's waitrequest = 1. An ineligible port's waitrequest = 1.
REQ-014 starve_cnt, 0..STARVE_LIMIT, saturating:
- increments each cycle imem_read = 1 and the I port is not accepted;
- clears to 0 on I accept, or when imem_read = 0.
REQ-015 perf_ic_starved SHALL increment (wrapping mod 2^32) on every cycle where the override of REQ-010 selects I over an eligible D.
REQ-016 Per-port outstanding counters SHALL:
- +1 on an accepted read (mem_read & ~mem_waitrequest & winner = port);
- -1 when mem_readdataid == port ID.
- Simultaneous +1 and -1 leave the count unchanged.
- A return with count 0 is ignored and the count stays 0; no underflow.
REQ-017 Return path is combinational, zero latency:
- dmem_readdatavalid = (mem_readdataid == 1); imem_readdatavalid = (mem_readdataid == 2).
- Both readdata outputs equal mem_readdata.
REQ-018 D-port read and write asserted together SHALL be forwarded unchanged as one transaction. The D outstanding count increments only if dmem_read = 1.
REQ-019 A strobe that drops while locked SHALL NOT be forwarded. The block drives mem_read = mem_write = 0 and keeps the lock until mem_waitrequest = 0; this is a protocol-violation tolerance.

Reset
REQ-020 While rst = 1, the following SHALL be forced to 0: lock, lock_owner, starve_cnt, both outstanding counters, perf_ic_starved.
REQ-021 While rst = 1, the combinational outputs SHALL be: mem_read = mem_write = 0, mem_id = 0, both waitrequests = 1.
REQ-022 Reset asserted mid-transaction SHALL discard the lock and all outstanding counts. Returns arriving after reset are ignored per the no-underflow rule of REQ-016.

Verification
REQ-023 Scenario: D and I read simultaneously, mem_waitrequest = 0.
- Expected: D is granted with mem_id = 1; I waitrequest = 1.
- On the next cycle, with D idle, I is granted with mem_id = 2.
REQ-024 Scenario: D reads every cycle, I reads continuously, STARVE_LIMIT = 8.
- Expected: I is granted in cycle 9, perf_ic_starved = 1, and starve_cnt is 0 afterwards.
REQ-025 Scenario: I presented with mem_waitrequest = 1 for 3 cycles while D asserts a read in cycle 2.
- Expected: mem_address stays at the I address for all 3 cycles; D is granted in cycle 4.
REQ-026 Scenario: 4 D reads accepted with no returns, MAX_OUTSTANDING = 4.
- Expected: a 5th read sees dmem_waitrequest = 1.
- After mem_readdataid = 1 for one cycle, the 5th read is accepted.
REQ-027 Scenario: readdataid = 2 with data 0xDEADBEEF.
- Expected: imem_readdatavalid = 1, imem_readdata = 0xDEADBEEF, dmem_readdatavalid = 0.
REQ-028 Scenario: rst pulsed while I is locked with 2 reads outstanding.
- Expected: afterwards, counters are 0, there is no lock, and a D read is granted immediately.
